// File: rtl/mul6_err_eval.sv
// -----------------------------------------------------------------------------
// mul6_err_eval
//
// Error evaluator for 6x6 -> 12-bit unsigned approximate multiplier netlists.
// A stream of (a, b, approximate product) samples is accepted. For each sample
// the exact product a*b is recomputed, and error statistics are collected over
// a run of N_SAMPLES samples. The harness reads the results when done pulses.
//
// Optional feature macro: MUL_ERR_SQ_EN
//   defined   -> adds a squarer and the saturating sum_se (sum of err^2) port
//   undefined -> no sum_se port and no squarer logic
//
// Ports
//   clk       in   1           clock, rising edge
//   rst       in   1           synchronous, active-high reset
//   start     in   1           begin a run (only looked at in IDLE)
//   in_valid  in   1           sample valid
//   in_ready  out  1           evaluator can accept a sample (RUN only)
//   in_a      in   A_W         operand A
//   in_b      in   B_W         operand B
//   in_p      in   P_W         approximate product under test
//   busy      out  1           run in progress (RUN or DRAIN)
//   done      out  1           one-cycle pulse, statistics final
//   err_cnt   out  13          number of samples with in_p != a*b
//   max_ae    out  P_W         maximum |in_p - a*b|
//   max_a     out  A_W         operand A of first sample reaching max_ae
//   max_b     out  B_W         operand B of first sample reaching max_ae
//   sum_ae    out  ACC_W       saturating sum of |err|
//   sum_se    out  ACC_W+P_W   saturating sum of err^2 (MUL_ERR_SQ_EN only)
//
// Pipeline
//   S1    : registers a, b, p and exact = a*b
//   S2    : registers ae = |p - exact|
//   stats : folds S2 into the statistics
//   A sample accepted in cycle t is visible in the statistics from cycle t+3,
//   which is also the cycle in which done pulses after the final sample.
// -----------------------------------------------------------------------------
module mul6_err_eval #(
   parameter int A_W       = 6,
   parameter int B_W       = 6,
   parameter int P_W       = 12,
   parameter int N_SAMPLES = 4096,
   parameter int ACC_W     = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [A_W-1:0]   in_a,
   input  logic [B_W-1:0]   in_b,
   input  logic [P_W-1:0]   in_p,
   output logic             busy,
   output logic             done,
   output logic [12:0]      err_cnt,
   output logic [P_W-1:0]   max_ae,
   output logic [A_W-1:0]   max_a,
   output logic [B_W-1:0]   max_b,
   output logic [ACC_W-1:0] sum_ae
`ifdef MUL_ERR_SQ_EN
   ,
   output logic [ACC_W+P_W-1:0] sum_se
`endif
);

   localparam int CNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);
   // Sum is formed one bit wider than the larger operand so carry-out is visible
   localparam int SUM_W = ((ACC_W > P_W) ? ACC_W : P_W) + 1;
   localparam logic [ACC_W-1:0] ACC_ONES = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic             w_clear;
   logic             w_xfer;
   logic             w_last;
   logic [CNT_W-1:0] r_cnt;

   // S1 registers
   logic             r_s1_valid;
   logic [A_W-1:0]   r_s1_a;
   logic [B_W-1:0]   r_s1_b;
   logic [P_W-1:0]   r_s1_p;
   logic [P_W-1:0]   r_s1_exact;
   logic [P_W-1:0]   w_exact;

   // S2 registers
   logic             r_s2_valid;
   logic [A_W-1:0]   r_s2_a;
   logic [B_W-1:0]   r_s2_b;
   logic [P_W-1:0]   r_s2_ae;
   logic [P_W-1:0]   w_ae;

   // Statistics
   logic [12:0]      r_err_cnt;
   logic [P_W-1:0]   r_max_ae;
   logic [A_W-1:0]   r_max_a;
   logic [B_W-1:0]   r_max_b;
   logic [ACC_W-1:0] r_sum_ae;
   logic [SUM_W-1:0] w_sum_ext;

   // ---------------------------------------------------------------- FSM
   assign w_xfer = in_valid & in_ready;
   assign w_last = w_xfer && (r_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_clear      = 1'b0;
      in_ready     = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_next = ST_RUN;
               w_clear      = 1'b1;
            end
         end
         ST_RUN: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (w_last) begin
               w_state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            busy = 1'b1;
            // Once S1 is empty, the sample left in S2 is folded into the
            // statistics on this same edge, so DONE sees final values.
            if (!r_s1_valid) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            done         = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_clear) begin
         r_cnt <= '0;
      end else if (w_xfer) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------- S1
   assign w_exact = P_W'(in_a) * P_W'(in_b);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_p     <= '0;
         r_s1_exact <= '0;
      end else begin
         r_s1_valid <= w_xfer;
         if (w_xfer) begin
            r_s1_a     <= in_a;
            r_s1_b     <= in_b;
            r_s1_p     <= in_p;
            r_s1_exact <= w_exact;
         end
      end
   end

   // ---------------------------------------------------------------- S2
   assign w_ae = (r_s1_p >= r_s1_exact) ? (r_s1_p - r_s1_exact)
                                        : (r_s1_exact - r_s1_p);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_a     <= '0;
         r_s2_b     <= '0;
         r_s2_ae    <= '0;
      end else begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_a  <= r_s1_a;
            r_s2_b  <= r_s1_b;
            r_s2_ae <= w_ae;
         end
      end
   end

   // ---------------------------------------------------------------- stats
   assign w_sum_ext = SUM_W'(r_sum_ae) + SUM_W'(r_s2_ae);

   always_ff @(posedge clk) begin
      if (rst || w_clear) begin
         r_err_cnt <= '0;
         r_max_ae  <= '0;
         r_max_a   <= '0;
         r_max_b   <= '0;
         r_sum_ae  <= '0;
      end else if (r_s2_valid) begin
         if ((r_s2_ae != '0) && (r_err_cnt != 13'h1FFF)) begin
            r_err_cnt <= r_err_cnt + 13'd1;
         end
         // Strict compare: on ties the earliest sample keeps ownership
         if (r_s2_ae > r_max_ae) begin
            r_max_ae <= r_s2_ae;
            r_max_a  <= r_s2_a;
            r_max_b  <= r_s2_b;
         end
         if (w_sum_ext > SUM_W'(ACC_ONES)) begin
            r_sum_ae <= ACC_ONES;
         end else begin
            r_sum_ae <= w_sum_ext[ACC_W-1:0];
         end
      end
   end

`ifdef MUL_ERR_SQ_EN
   localparam int SQ_W  = 2 * P_W;
   localparam int SE_W  = ACC_W + P_W;
   localparam int SE_XW = ((SE_W > SQ_W) ? SE_W : SQ_W) + 1;
   localparam logic [SE_W-1:0] SE_ONES = '1;

   logic [SE_W-1:0]  r_sum_se;
   logic [SQ_W-1:0]  w_sq;
   logic [SE_XW-1:0] w_se_ext;

   assign w_sq     = SQ_W'(r_s2_ae) * SQ_W'(r_s2_ae);
   assign w_se_ext = SE_XW'(r_sum_se) + SE_XW'(w_sq);

   always_ff @(posedge clk) begin
      if (rst || w_clear) begin
         r_sum_se <= '0;
      end else if (r_s2_valid) begin
         if (w_se_ext > SE_XW'(SE_ONES)) begin
            r_sum_se <= SE_ONES;
         end else begin
            r_sum_se <= w_se_ext[SE_W-1:0];
         end
      end
   end

   assign sum_se = r_sum_se;
`endif

   assign err_cnt = r_err_cnt;
   assign max_ae  = r_max_ae;
   assign max_a   = r_max_a;
   assign max_b   = r_max_b;
   assign sum_ae  = r_sum_ae;

endmodule
